// File: rtl/fp_addsub_pipe.sv
// IEEE-754 binary add/sub, 3-stage valid/ready pipe: S1 unpack/align, S2 add/normalise, S3 round/pack.
// Latency 3, throughput 1/cycle; empty stages load even when downstream stalls, so up to 3 results buffer.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0]    ONE_EW  = EW'(1);
  localparam logic [EW-1:0]    EXP_INF = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] ONE_E   = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic v1, v2, adv1, adv2, adv3;
  assign adv3     = !out_valid | out_ready;
  assign adv2     = !v2 | adv3;
  assign adv1     = !v1 | adv2;
  assign in_ready = adv1;

  // ---------------- S1: classify, swap, align ----------------
  logic             sa, sb, a_den, b_den, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign sa = a[W-1];
  assign sb = b[W-1] ^ sub;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign a_den  = (ea == '0);
  assign b_den  = (eb == '0);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];

  logic              swap, xs, ys, c_byp;
  logic [EXP_W-1:0]  xe, ye;
  logic [SW-1:0]     xsig, ysig, yal;
  logic [2*SW-1:0]   ywide;
  logic [W-1:0]      c_byp_res;
  logic [2:0]        c_byp_flg;
  int                d;

  always_comb begin
    swap  = b[W-2:0] > a[W-2:0];
    xs    = swap ? sb : sa;
    ys    = swap ? sa : sb;
    xe    = swap ? (b_den ? ONE_E : eb) : (a_den ? ONE_E : ea);
    ye    = swap ? (a_den ? ONE_E : ea) : (b_den ? ONE_E : eb);
    xsig  = swap ? {~b_den, fb, 3'b000} : {~a_den, fa, 3'b000};
    ysig  = swap ? {~a_den, fa, 3'b000} : {~b_den, fb, 3'b000};
    d     = int'(xe) - int'(ye);
    if (d > SW) d = SW;
    // Lower half of the wide shift collects everything pushed past the sticky position.
    ywide = {ysig, {SW{1'b0}}} >> d;
    yal   = {ywide[2*SW-1:SW+1], ywide[SW] | (|ywide[SW-1:0])};

    c_byp     = a_nan | b_nan | a_inf | b_inf;
    c_byp_res = QNAN;
    c_byp_flg = 3'b000;
    if (a_nan | b_nan) begin
      c_byp_flg = {a_snan | b_snan, 2'b00};
    end else if (a_inf & b_inf & (sa != sb)) begin
      c_byp_flg = 3'b100;
    end else if (a_inf) begin
      c_byp_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      c_byp_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic             s1_byp, s1_xs, s1_ys;
  logic [W-1:0]     s1_byp_res;
  logic [2:0]       s1_byp_flg;
  logic [EXP_W-1:0] s1_xe;
  logic [SW-1:0]    s1_xsig, s1_ysig;

  // ---------------- S2: add/subtract, normalise ----------------
  logic          eff_sub, n_sign;
  logic [SW:0]   sum;
  logic [SW-1:0] norm, n_sig;
  logic [EW-1:0] n_exp;
  int            lz, lim, sh;

  always_comb begin
    eff_sub = s1_xs ^ s1_ys;
    sum = eff_sub ? ({1'b0, s1_xsig} - {1'b0, s1_ysig}) : ({1'b0, s1_xsig} + {1'b0, s1_ysig});
    lz = SW;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lz = SW - 1 - i;
    end
    // Never shift below the minimum exponent; if the limit bites the hidden bit stays clear.
    lim  = int'(s1_xe) - 1;
    sh   = (lz < lim) ? lz : lim;
    norm = sum[SW-1:0] << sh;
    n_sign = (eff_sub && (sum == '0)) ? 1'b0 : s1_xs;
    if (sum[SW]) begin
      n_sig = {sum[SW:2], sum[1] | sum[0]};
      n_exp = {1'b0, s1_xe} + ONE_EW;
    end else begin
      n_sig = norm;
      n_exp = norm[SW-1] ? ({1'b0, s1_xe} - EW'(sh)) : '0;
    end
  end

  logic          s2_byp, s2_sign;
  logic [W-1:0]  s2_byp_res;
  logic [2:0]    s2_byp_flg;
  logic [EW-1:0] s2_exp;
  logic [SW-1:0] s2_sig;

  // ---------------- S3: round to nearest even, pack ----------------
  logic             g, r, s, up;
  logic [MAN_W+1:0] mant;
  logic [EW-1:0]    e3;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res;
  logic [2:0]       flg;

  always_comb begin
    g    = s2_sig[2];
    r    = s2_sig[1];
    s    = s2_sig[0];
    up   = g & (r | s | s2_sig[3]);
    mant = {1'b0, s2_sig[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    e3   = s2_exp;
    frac = mant[MAN_W-1:0];
    if (mant[MAN_W+1]) begin
      e3   = s2_exp + ONE_EW;
      frac = mant[MAN_W:1];
    end else if ((s2_exp == '0) && mant[MAN_W]) begin
      e3 = ONE_EW;
    end
    if (s2_byp) begin
      res = s2_byp_res;
      flg = s2_byp_flg;
    end else if (e3 >= EXP_INF) begin
      res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 3'b011;
    end else begin
      res = {s2_sign, e3[EXP_W-1:0], frac};
      flg = {2'b00, g | r | s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; v2 <= 1'b0; out_valid <= 1'b0;
      s1_byp <= 1'b0; s1_byp_res <= '0; s1_byp_flg <= '0; s1_xs <= 1'b0; s1_ys <= 1'b0;
      s1_xe <= '0; s1_xsig <= '0; s1_ysig <= '0;
      s2_byp <= 1'b0; s2_byp_res <= '0; s2_byp_flg <= '0; s2_sign <= 1'b0;
      s2_exp <= '0; s2_sig <= '0;
      result <= '0; flags <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv1 && in_valid) begin
        s1_byp <= c_byp; s1_byp_res <= c_byp_res; s1_byp_flg <= c_byp_flg;
        s1_xs <= xs; s1_ys <= ys; s1_xe <= xe; s1_xsig <= xsig; s1_ysig <= yal;
      end
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        s2_byp <= s1_byp; s2_byp_res <= s1_byp_res; s2_byp_flg <= s1_byp_flg;
        s2_sign <= n_sign; s2_exp <= n_exp; s2_sig <= n_sig;
      end
      if (adv3) out_valid <= v2;
      if (adv3 && v2) begin
        result <= res;
        flags  <= flg;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary32): directed cases, backpressure, reset, then random traffic
// scored against an exact wide-integer reference model.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  flags;

  int          tests = 0;
  int          fails = 0;
  int          n_out = 0;
  logic [34:0] sb [$];
  logic [34:0] mon_e;
  logic [31:0] specials [8];
  logic [31:0] bp_a [6];
  logic [31:0] bp_r [6];

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Exact reference: operands become integers in units of the smallest subnormal.
  function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic         sx, sy, rs, inx, up, xn, yn;
    logic [7:0]   ex, ey;
    logic [22:0]  fx, fy;
    logic [319:0] mx, my, mag, rem, half;
    logic [24:0]  keep;
    int           p, sh, e;
    sx = x[31]; sy = y[31] ^ s;
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    xn = (ex == 8'hFF) && (fx != 0);
    yn = (ey == 8'hFF) && (fy != 0);
    if (xn || yn) return {(xn && !fx[22]) || (yn && !fy[22]), 2'b00, 32'h7FC00000};
    if (ex == 8'hFF && ey == 8'hFF) return (sx != sy) ? {3'b100, 32'h7FC00000} : {3'b000, sx, 8'hFF, 23'd0};
    if (ex == 8'hFF) return {3'b000, sx, 8'hFF, 23'd0};
    if (ey == 8'hFF) return {3'b000, sy, 8'hFF, 23'd0};
    mx = '0; mx[23:0] = {ex != 0, fx}; if (ex != 0) mx = mx << (ex - 8'd1);
    my = '0; my[23:0] = {ey != 0, fy}; if (ey != 0) my = my << (ey - 8'd1);
    if (sx == sy) begin mag = mx + my; rs = sx; end
    else if (mx >= my) begin mag = mx - my; rs = sx; end
    else begin mag = my - mx; rs = sy; end
    if (mag == 0) return {3'b000, (sx == sy) ? sx : 1'b0, 31'd0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    if (p < 23) return {3'b000, rs, 8'd0, mag[22:0]};
    sh   = p - 23;
    e    = p - 22;
    keep = 25'(mag >> sh);
    rem  = mag & ((320'd1 << sh) - 320'd1);
    half = (sh > 0) ? (320'd1 << (sh - 1)) : '0;
    inx  = (rem != 0);
    up   = (sh > 0) && ((rem > half) || ((rem == half) && keep[0]));
    keep = keep + {24'd0, up};
    if (keep[24]) begin keep = keep >> 1; e++; end
    if (e >= 255) return {3'b011, rs, 8'hFF, 23'd0};
    return {2'b00, inx, rs, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] o);
    logic [31:0] rv;
    int          e;
    rv = $urandom;
    case ($urandom_range(0, 9))
      0: rv = specials[$urandom_range(0, 7)];
      1: rv[30:23] = 8'd0;
      2, 3, 4: begin
        e = int'(o[30:23]) + int'($urandom_range(0, 10)) - 5;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        rv[30:23] = 8'(e);
      end
      5: rv = o ^ 32'h8000_0000;
      6: begin
        e = int'(o[30:23]) - int'($urandom_range(20, 30));
        if (e < 0) e = 0;
        rv[30:23] = 8'(e);
      end
      default: ;
    endcase
    return rv;
  endfunction

  // Called at posedge+1; presents one cycle of stimulus and records the expectation on accept.
  task automatic drive_cycle(input logic v, input logic [31:0] xa, input logic [31:0] xb,
                             input logic xs, input logic [34:0] want, output logic acc);
    in_valid = v; a = xa; b = xb; sub = xs;
    @(negedge clk);
    acc = v & in_ready;
    if (acc) sb.push_back(want);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic xs, input logic [34:0] want);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) drive_cycle(1'b1, xa, xb, xs, want, acc);
    in_valid = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin @(posedge clk); #1; end
    chk("drained", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      n_out++;
      chk("output_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("result", 64'(result), 64'(mon_e[31:0]));
        chk("flags", 64'(flags), 64'(mon_e[34:32]));
      end
    end
  end

  initial begin
    logic        acc, rs;
    logic [31:0] ra, rb;
    int          lat, n0;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h7F7F_FFFF};
    bp_a = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
    bp_r = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40A0_0000};
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h4000_0000});
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    @(posedge clk); #1;

    send(32'h3F80_0000, 32'h3F80_0000, 1'b1, {3'b000, 32'h0000_0000});
    send(32'h8000_0000, 32'h0000_0000, 1'b1, {3'b000, 32'h8000_0000});
    send(32'h3F80_0000, 32'h3380_0000, 1'b0, {3'b001, 32'h3F80_0000});
    send(32'h3F80_0001, 32'h3380_0000, 1'b0, {3'b001, 32'h3F80_0002});
    send(32'h7F80_0000, 32'hFF80_0000, 1'b0, {3'b100, 32'h7FC0_0000});
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, {3'b011, 32'h7F80_0000});
    send(32'h0000_0001, 32'h0000_0001, 1'b0, {3'b000, 32'h0000_0002});
    send(32'h0080_0000, 32'h0000_0001, 1'b1, {3'b000, 32'h007F_FFFF});
    send(32'h7F80_0001, 32'h3F80_0000, 1'b0, {3'b100, 32'h7FC0_0000});
    send(32'h7FC0_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'h7FC0_0000});
    send(32'hFF80_0000, 32'h3F80_0000, 1'b0, {3'b000, 32'hFF80_0000});
    send(32'h3F80_0000, 32'h8000_0000, 1'b1, {3'b000, 32'h3F80_0000});
    send(32'h0000_0000, 32'h8000_0000, 1'b0, {3'b000, 32'h0000_0000});
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, {3'b100, 32'h7FC0_0000});
    send(32'h4040_0000, 32'h3F80_0000, 1'b1, {3'b000, 32'h4000_0000});
    send(32'h3F80_0000, 32'hBF7F_FFFF, 1'b0, {3'b000, 32'h3380_0000});
    drain();

    // Full backpressure: three accepts fill the pipe, the fourth must be refused.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, bp_a[k], 32'h3F80_0000, 1'b0, {3'b000, bp_r[k]}, acc);
      chk("bp_accept", 64'(acc), 64'(k < 3));
    end
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, bp_a[3], 32'h3F80_0000, 1'b0, {3'b000, bp_r[3]}, acc);
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_result", 64'(result), 64'(bp_r[0]));
    n0 = n_out;
    out_ready = 1'b1;
    for (int k = 3; k < 6; k++) send(bp_a[k], 32'h3F80_0000, k == 5, {3'b000, bp_r[k]});
    drain();
    chk("bp_out_count", 64'(n_out - n0), 64'd6);

    // Asynchronous reset with data in flight discards everything.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(bp_a[k], 32'h3F80_0000, 1'b0, {3'b000, bp_r[k]});
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", 64'(out_valid), 64'd0);

    for (int n = 0; n < 10000; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      ra = rand_op($urandom);
      rb = rand_op(ra);
      rs = 1'($urandom_range(0, 1));
      drive_cycle($urandom_range(0, 3) != 0, ra, rb, rs, ref_model(ra, rb, rs), acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised IEEE-754 binary floating-point adder/subtractor for the NPU datapath. It is the next generation of the single-precision adder. It adds runtime add/sub selection, round-to-nearest-even, correct special-value handling and exception flags. It uses a 3-stage valid/ready pipeline with per-stage bubble collapsing and sits between accumulation buffers and the post-processing unit.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width; total width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands this cycle
a  in  W  operand A
b  in  W  operand B
sub  in  1  0: a+b, 1: a-b (B sign inverted at entry)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  rounded result
flags  out  3  {invalid, overflow, inexact}, aligned with result

Behaviour:
- Reset is rst_n (asynchronous, active-low); clock is clk. On reset all stage valid bits, out_valid, result and flags go to 0. Reset mid-operation discards all in-flight data.
- Pipeline has stages S1, S2 and S3; S3 registers drive result, flags and out_valid directly.
  - S3 advance = !v3 | out_ready.
  - S2 advance = !v2 | S3 advance.
  - S1 advance = !v1 | S2 advance.
  - in_ready = S1 advance (combinational from out_ready and valid bits).
- Transfer occurs on in_valid & in_ready and on out_valid & out_ready.
- Latency is 3 cycles with no stall; throughput is 1 per cycle. Order is preserved. A stalled stage holds its contents and does not change.
- Bubbles collapse: an empty stage loads even when downstream is stalled. The pipe holds up to 3 results under full backpressure.
- S1 (unpack/align):
  - Classify each operand as zero, subnormal (exp 0, hidden bit 0, effective exp 1), normal, inf or NaN. Apply sub to B's sign.
  - Swap so the larger magnitude is X.
  - Shift Y right by the exponent difference into a MAN_W+4 bit significand: hidden bit, fraction, guard, round, sticky. Bits shifted beyond the width OR into sticky. A shift ≥ MAN_W+3 leaves only sticky.
- S2 (add/normalise):
  - Effective op is add if signs are equal, else subtract (X-Y, never negative).
  - On carry-out, shift right 1, exp+1, sticky keeps the OR.
  - Otherwise count leading zeros and shift left by min(lz, exp_X-1). If the limit applies, the result is subnormal (exp 0).
- S3 (round/pack):
  - Round to nearest even: round up if G & (R|S|LSB).
  - Mantissa overflow after rounding increments exp; a subnormal rounding up to the hidden bit becomes exp 1.
  - Exp ≥ 2^EXP_W-1 gives ±inf with overflow=1 and inexact=1.
  - inexact = G|R|S before rounding.
- Special cases, resolved in S1 and carried as a bypass:
  - Any NaN input gives canonical qNaN (sign 0, exp all-ones, fraction MSB 1) with invalid=0, unless either input is signalling, which sets invalid=1.
  - inf + (-inf) effective gives qNaN, invalid=1.
  - inf op finite gives that inf.
- Zero sign:
  - Exact-zero sum of opposite-sign operands gives +0.
  - (-0)+(-0) gives -0.
  - x±0 gives x exactly, flags 0.
- flags are sticky per-result only (not accumulated).

Test Plan:
- W=32: a=0x3F800000, b=0x3F800000, sub=0 → result 0x40000000, flags 000, out_valid exactly 3 cycles after accept.
- a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000. a=0x80000000, b=0x00000000, sub=1 → 0x80000000.
- Rounding:
  - a=0x3F800000, b=0x33800000 (2^-24, exact tie) → 0x3F800000 inexact=1.
  - a=0x3F800001, b=0x33800000 → 0x3F800002 inexact=1.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
- Subnormals:
  - 0x00000001 + 0x00000001 → 0x00000002.
  - 0x00800000 sub 0x00000001 → 0x007FFFFF, flags 000.
- Backpressure: stream 6 ops back-to-back with out_ready=0 → in_ready drops after the 3rd accept. Release out_ready → 6 results in order, no loss or duplication. Random out_ready/in_valid over 10k vectors must match the reference model bit-exactly, flags included.
